// File: rtl/bitonic_sorter_if.sv
// Handshake and data bus between a candidate producer and the bitonic sorter.
// Latency: none (wires only).
// Backpressure: none; the sorter accepts every valid set.
interface bitonic_sorter_if #(
    parameter int DATA_WIDTH  = 11,
    parameter int INDEX_WIDTH = 9
);
    logic                   valid_in;
    logic [DATA_WIDTH-1:0]  data_in_0, data_in_1, data_in_2, data_in_3;
    logic [DATA_WIDTH-1:0]  data_in_4, data_in_5, data_in_6, data_in_7;
    logic [INDEX_WIDTH-1:0] indices_in_0, indices_in_1, indices_in_2, indices_in_3;
    logic [INDEX_WIDTH-1:0] indices_in_4, indices_in_5, indices_in_6, indices_in_7;

    logic                   valid_out;
    logic [DATA_WIDTH-1:0]  data_out_0, data_out_1, data_out_2, data_out_3;
    logic [INDEX_WIDTH-1:0] indices_out_0, indices_out_1, indices_out_2, indices_out_3;

    modport master (
        output valid_in,
        output data_in_0, data_in_1, data_in_2, data_in_3,
        output data_in_4, data_in_5, data_in_6, data_in_7,
        output indices_in_0, indices_in_1, indices_in_2, indices_in_3,
        output indices_in_4, indices_in_5, indices_in_6, indices_in_7,
        input  valid_out,
        input  data_out_0, data_out_1, data_out_2, data_out_3,
        input  indices_out_0, indices_out_1, indices_out_2, indices_out_3
    );

    modport slave (
        input  valid_in,
        input  data_in_0, data_in_1, data_in_2, data_in_3,
        input  data_in_4, data_in_5, data_in_6, data_in_7,
        input  indices_in_0, indices_in_1, indices_in_2, indices_in_3,
        input  indices_in_4, indices_in_5, indices_in_6, indices_in_7,
        output valid_out,
        output data_out_0, data_out_1, data_out_2, data_out_3,
        output indices_out_0, indices_out_1, indices_out_2, indices_out_3
    );
endinterface

// File: rtl/bitonic_sorter.sv
// 8-input bitonic sorting network returning the four smallest {key, tag} pairs, ascending.
// Latency: 3 cycles, or 6 with BITONIC_SORTER_FULL_PIPE_EN defined (register after every stage).
// Backpressure: none; one set per cycle, outputs hold the last valid result when idle.
module bitonic_sorter #(
    parameter int DATA_WIDTH  = 11,
    parameter int INDEX_WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    bitonic_sorter_if.slave  bus
);
    // Elements compare as {key, tag}, so key ties resolve by lower tag.
    localparam int EW = DATA_WIDTH + INDEX_WIDTH;
    typedef logic [EW-1:0]       elem_t;
    typedef logic [7:0][EW-1:0]  lanes_t;

    // Block size of the bitonic sequence being merged at stage s.
    function automatic int stage_k(input int s);
        case (s)
            0:       return 2;
            1, 2:    return 4;
            default: return 8;
        endcase
    endfunction

    // Compare distance at stage s.
    function automatic int stage_j(input int s);
        case (s)
            0, 2, 5: return 1;
            1, 4:    return 2;
            default: return 4;
        endcase
    endfunction

    // Which stages end in a pipeline register; the last one always does.
    function automatic bit reg_after(input int s);
`ifdef BITONIC_SORTER_FULL_PIPE_EN
        return (s >= 0);
`else
        return (s == 0) || (s == 2) || (s == 5);
`endif
    endfunction

    // One compare-exchange stage: lane i pairs with i|j; direction is ascending when bit k of i is 0.
    function automatic lanes_t cx(input lanes_t a, input int k, input int j);
        lanes_t     r;
        logic [2:0] ia;
        logic [2:0] ib;
        logic       up;
        elem_t      lo;
        elem_t      hi;
        r = a;
        for (int i = 0; i < 8; i++) begin
            if ((i & j) == 0) begin
                ia = 3'(i);
                ib = 3'(i | j);
                up = ((i & k) == 0);
                lo = (a[ia] < a[ib]) ? a[ia] : a[ib];
                hi = (a[ia] < a[ib]) ? a[ib] : a[ia];
                r[ia] = up ? lo : hi;
                r[ib] = up ? hi : lo;
            end
        end
        return r;
    endfunction

    lanes_t in_lanes;
    assign in_lanes[0] = {bus.data_in_0, bus.indices_in_0};
    assign in_lanes[1] = {bus.data_in_1, bus.indices_in_1};
    assign in_lanes[2] = {bus.data_in_2, bus.indices_in_2};
    assign in_lanes[3] = {bus.data_in_3, bus.indices_in_3};
    assign in_lanes[4] = {bus.data_in_4, bus.indices_in_4};
    assign in_lanes[5] = {bus.data_in_5, bus.indices_in_5};
    assign in_lanes[6] = {bus.data_in_6, bus.indices_in_6};
    assign in_lanes[7] = {bus.data_in_7, bus.indices_in_7};

    for (genvar s = 0; s < 6; s++) begin : g_stage
        lanes_t din;
        logic   vin;
        lanes_t cmb;
        lanes_t dat;
        logic   vld;

        if (s == 0) begin : g_src
            assign din = in_lanes;
            assign vin = bus.valid_in;
        end else begin : g_chain
            assign din = g_stage[s-1].dat;
            assign vin = g_stage[s-1].vld;
        end

        assign cmb = cx(din, stage_k(s), stage_j(s));

        if (reg_after(s)) begin : g_reg
            // Stage register: valid always advances, data loads only with a valid set.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld <= 1'b0;
                    dat <= '0;
                end else begin
                    vld <= vin;
                    if (vin) begin
                        dat <= cmb;
                    end
                end
            end
        end else begin : g_wire
            assign vld = vin;
            assign dat = cmb;
        end
    end

    // Final stage is always registered; the upper four lanes are discarded.
    lanes_t res;
    assign res = g_stage[5].dat;

    assign bus.valid_out     = g_stage[5].vld;
    assign bus.data_out_0    = res[0][EW-1:INDEX_WIDTH];
    assign bus.data_out_1    = res[1][EW-1:INDEX_WIDTH];
    assign bus.data_out_2    = res[2][EW-1:INDEX_WIDTH];
    assign bus.data_out_3    = res[3][EW-1:INDEX_WIDTH];
    assign bus.indices_out_0 = res[0][INDEX_WIDTH-1:0];
    assign bus.indices_out_1 = res[1][INDEX_WIDTH-1:0];
    assign bus.indices_out_2 = res[2][INDEX_WIDTH-1:0];
    assign bus.indices_out_3 = res[3][INDEX_WIDTH-1:0];
endmodule

// File: tb/tb_bitonic_sorter.sv
// Randomized and directed checks of bitonic_sorter against a plain sort model.
module tb_bitonic_sorter;
    localparam int DW = 11;
    localparam int IW = 9;
`ifdef BITONIC_SORTER_FULL_PIPE_EN
    localparam int L = 6;
`else
    localparam int L = 3;
`endif

    typedef logic [7:0][DW-1:0] keys_t;
    typedef logic [7:0][IW-1:0] tags_t;
    typedef logic [3:0][DW-1:0] dvec_t;
    typedef logic [3:0][IW-1:0] ivec_t;
    typedef struct packed {
        logic [31:0] due;
        dvec_t       d;
        ivec_t       i;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bitonic_sorter_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) bus ();
    bitonic_sorter #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    exp_t  q[$];
    logic  exp_v;
    dvec_t exp_d;
    ivec_t exp_i;
    dvec_t od;
    ivec_t oi;

    // Reference: full ascending sort of the eight {key,tag} pairs, keep the first four.
    function automatic exp_t model(input keys_t k, input tags_t t);
        logic [DW+IW-1:0] e[8];
        logic [DW+IW-1:0] tmp;
        exp_t r;
        for (int n = 0; n < 8; n++) e[n] = {k[n], t[n]};
        for (int a = 0; a < 8; a++)
            for (int b = a + 1; b < 8; b++)
                if (e[b] < e[a]) begin
                    tmp = e[a]; e[a] = e[b]; e[b] = tmp;
                end
        r.due = '0;
        for (int n = 0; n < 4; n++) begin
            r.d[n] = e[n][DW+IW-1:IW];
            r.i[n] = e[n][IW-1:0];
        end
        return r;
    endfunction

    function automatic keys_t rand_keys(input bit narrow);
        keys_t k;
        for (int n = 0; n < 8; n++)
            k[n] = narrow ? DW'($urandom_range(0, 5)) : DW'($urandom);
        return k;
    endfunction

    function automatic tags_t rand_tags();
        tags_t t;
        for (int n = 0; n < 8; n++) t[n] = IW'($urandom);
        return t;
    endfunction

    task automatic drive(input logic v, input keys_t k, input tags_t t);
        bus.valid_in = v;
        bus.data_in_0 = k[0]; bus.data_in_1 = k[1]; bus.data_in_2 = k[2]; bus.data_in_3 = k[3];
        bus.data_in_4 = k[4]; bus.data_in_5 = k[5]; bus.data_in_6 = k[6]; bus.data_in_7 = k[7];
        bus.indices_in_0 = t[0]; bus.indices_in_1 = t[1]; bus.indices_in_2 = t[2]; bus.indices_in_3 = t[3];
        bus.indices_in_4 = t[4]; bus.indices_in_5 = t[5]; bus.indices_in_6 = t[6]; bus.indices_in_7 = t[7];
    endtask

    task automatic sample();
        od[0] = bus.data_out_0; od[1] = bus.data_out_1; od[2] = bus.data_out_2; od[3] = bus.data_out_3;
        oi[0] = bus.indices_out_0; oi[1] = bus.indices_out_1; oi[2] = bus.indices_out_2; oi[3] = bus.indices_out_3;
    endtask

    // Drive one cycle, clock it, and update the expected output state from the scoreboard queue.
    task automatic step(input logic v, input keys_t k, input tags_t t);
        exp_t e;
        drive(v, k, t);
        if (v) begin
            e = model(k, t);
            e.due = 32'(cyc + L);
            q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        #1;
        exp_v = 1'b0;
        if (q.size() > 0 && q[0].due == 32'(cyc)) begin
            exp_v = 1'b1;
            exp_d = q[0].d;
            exp_i = q[0].i;
            void'(q.pop_front());
        end
        sample();
    endtask

    task automatic step_idle();
        step(1'b0, rand_keys(1'b0), rand_tags());
    endtask

    function automatic keys_t mk_keys(input int a0, a1, a2, a3, a4, a5, a6, a7);
        keys_t k;
        k[0] = DW'(a0); k[1] = DW'(a1); k[2] = DW'(a2); k[3] = DW'(a3);
        k[4] = DW'(a4); k[5] = DW'(a5); k[6] = DW'(a6); k[7] = DW'(a7);
        return k;
    endfunction

    function automatic tags_t mk_tags(input int a0, a1, a2, a3, a4, a5, a6, a7);
        tags_t t;
        t[0] = IW'(a0); t[1] = IW'(a1); t[2] = IW'(a2); t[3] = IW'(a3);
        t[4] = IW'(a4); t[5] = IW'(a5); t[6] = IW'(a6); t[7] = IW'(a7);
        return t;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        q.delete();
        exp_d = '0;
        exp_i = '0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, rand_keys(1'b0), rand_tags());
            @(posedge clk);
            #1;
            sample();
            checks++;
            if (bus.valid_out !== 1'b0) begin
                failures++;
                $display("FAIL reset_valid cyc=%0d got=%b exp=0", c, bus.valid_out);
            end
            checks++;
            if (od !== '0 || oi !== '0) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got d=%h i=%h exp 0", c, od, oi);
            end
        end
        drive(1'b0, rand_keys(1'b0), rand_tags());
        rst_n = 1'b1;
        for (int c = 0; c < L + 2; c++) begin
            step_idle();
            checks++;
            if (bus.valid_out !== 1'b0 || od !== '0 || oi !== '0) begin
                failures++;
                $display("FAIL post_reset_idle cyc=%0d got v=%b d=%h i=%h exp all 0", c, bus.valid_out, od, oi);
            end
        end
    endtask

    task automatic test_basic();
        int nv = 0;
        step(1'b1, mk_keys(3, 20, 124, 826, 0, 125, 83, 283), mk_tags(1, 2, 4, 7, 0, 5, 3, 6));
        for (int c = 1; c <= L + 2; c++) begin
            checks++;
            if (bus.valid_out !== exp_v || (exp_v == (c != L))) begin
                failures++;
                $display("FAIL basic_valid cyc=%0d got=%b exp=%b", c, bus.valid_out, c == L);
            end
            checks++;
            if (od !== exp_d || oi !== exp_i) begin
                failures++;
                $display("FAIL basic_data cyc=%0d got d=%h i=%h exp d=%h i=%h", c, od, oi, exp_d, exp_i);
            end
            if (bus.valid_out === 1'b1) begin
                nv++;
                checks++;
                if (od !== {11'd83, 11'd20, 11'd3, 11'd0} || oi !== {9'd3, 9'd2, 9'd1, 9'd0}) begin
                    failures++;
                    $display("FAIL basic_known got d=%h i=%h exp d={0,3,20,83} i={0,1,2,3}", od, oi);
                end
            end
            if (c < L + 2) step_idle();
        end
        checks++;
        if (nv != 1) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=1", nv);
        end
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int nv = 0;
        step(1'b1, mk_keys(3, 20, 124, 826, 0, 125, 83, 283), mk_tags(1, 2, 4, 7, 0, 5, 3, 6));
        step(1'b1, mk_keys(300, 2, 1, 11, 16, 2, 12, 339), mk_tags(6, 2, 0, 3, 5, 1, 4, 7));
        for (int c = 2; c <= L + 3; c++) begin
            checks++;
            if (bus.valid_out !== exp_v || od !== exp_d || oi !== exp_i) begin
                failures++;
                $display("FAIL b2b_cycle cyc=%0d got v=%b d=%h i=%h exp v=%b d=%h i=%h",
                         c, bus.valid_out, od, oi, exp_v, exp_d, exp_i);
            end
            if (bus.valid_out === 1'b1) begin
                if (first < 0) first = c;
                nv++;
                if (nv == 2) begin
                    checks++;
                    if (od !== {11'd11, 11'd2, 11'd2, 11'd1} || oi !== {9'd3, 9'd2, 9'd1, 9'd0} || c != first + 1) begin
                        failures++;
                        $display("FAIL b2b_tie got d=%h i=%h cyc=%0d exp d={1,2,2,11} i={0,1,2,3} consecutive", od, oi, c);
                    end
                end
            end
            step_idle();
        end
        checks++;
        if (nv != 2) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=2", nv);
        end
    endtask

    task automatic test_extremes();
        int nv = 0;
        step(1'b1, mk_keys(2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047), mk_tags(7, 6, 5, 4, 3, 2, 1, 0));
        step(1'b1, mk_keys(0, 0, 0, 0, 0, 0, 0, 0), mk_tags(7, 6, 5, 4, 3, 2, 1, 0));
        for (int c = 2; c <= L + 3; c++) begin
            checks++;
            if (bus.valid_out !== exp_v || od !== exp_d || oi !== exp_i) begin
                failures++;
                $display("FAIL extremes_cycle cyc=%0d got v=%b d=%h i=%h exp v=%b d=%h i=%h",
                         c, bus.valid_out, od, oi, exp_v, exp_d, exp_i);
            end
            if (bus.valid_out === 1'b1) begin
                nv++;
                checks++;
                if (oi !== {9'd3, 9'd2, 9'd1, 9'd0} || od !== ((nv == 1) ? {4{11'd2047}} : '0)) begin
                    failures++;
                    $display("FAIL extremes_known n=%0d got d=%h i=%h exp i={0,1,2,3}", nv, od, oi);
                end
            end
            step_idle();
        end
    endtask

    task automatic test_bubble();
        int vseen = 0;
        step(1'b1, rand_keys(1'b0), rand_tags());
        step(1'b0, rand_keys(1'b0), rand_tags());
        step(1'b1, rand_keys(1'b0), rand_tags());
        for (int c = 3; c <= L + 4; c++) begin
            checks++;
            if (bus.valid_out !== exp_v || od !== exp_d || oi !== exp_i) begin
                failures++;
                $display("FAIL bubble_cycle cyc=%0d got v=%b d=%h i=%h exp v=%b d=%h i=%h",
                         c, bus.valid_out, od, oi, exp_v, exp_d, exp_i);
            end
            vseen = (vseen << 1) | int'(bus.valid_out === 1'b1);
            step_idle();
        end
        checks++;
        if (vseen != (5 << (L + 4 - (L + 2)))) begin
            failures++;
            $display("FAIL bubble_pattern got=%b exp=101 then idle", vseen);
        end
    endtask

    task automatic test_random();
        logic v;
        for (int n = 0; n < 60 + L; n++) begin
            v = (n < 60) && ($urandom_range(0, 3) != 0);
            step(v, rand_keys($urandom_range(0, 1) == 1), rand_tags());
            checks++;
            if (bus.valid_out !== exp_v || od !== exp_d || oi !== exp_i) begin
                failures++;
                $display("FAIL random_cycle n=%0d got v=%b d=%h i=%h exp v=%b d=%h i=%h",
                         n, bus.valid_out, od, oi, exp_v, exp_d, exp_i);
            end
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, rand_keys(1'b0), rand_tags());
        step_idle();
        #2;
        rst_n = 1'b0;
        #1;
        sample();
        q.delete();
        exp_d = '0;
        exp_i = '0;
        checks++;
        if (bus.valid_out !== 1'b0 || od !== '0 || oi !== '0) begin
            failures++;
            $display("FAIL async_clear got v=%b d=%h i=%h exp all 0", bus.valid_out, od, oi);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < L + 3; c++) begin
            step_idle();
            checks++;
            if (bus.valid_out !== 1'b0 || od !== '0 || oi !== '0) begin
                failures++;
                $display("FAIL async_dropped cyc=%0d got v=%b d=%h i=%h exp all 0", c, bus.valid_out, od, oi);
            end
        end
    endtask

    initial begin
        exp_v = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_extremes();
        test_bubble();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
